// File: rtl/fc_argmax_pkg.sv
// Shared types and helpers for the fc_argmax streaming argmax stage.
package fc_argmax_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  // Index width never collapses to zero, so M==1 still gets a 1-bit index.
  function automatic int idx_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fc_argmax_ctrl.sv
// Handshake FSM and beat counter for fc_argmax; emits accept/first/last beat strobes.
module fc_argmax_ctrl
  import fc_argmax_pkg::*;
#(
  parameter int M    = 4,
  parameter int IDXW = idx_width(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            input_valid,
  input  logic            output_ready,
  output logic            input_ready,
  output logic            output_valid,
  output logic            accept,
  output logic            first_beat,
  output logic            last_beat,
  output logic [IDXW-1:0] cnt
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(M - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic            input_ready_q, output_valid_q;

  assign accept       = input_valid && input_ready_q;
  assign first_beat   = accept && (cnt_q == '0);
  assign last_beat    = accept && (cnt_q == LAST_IDX);
  assign input_ready  = input_ready_q;
  assign output_valid = output_valid_q;
  assign cnt          = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_COLLECT;
      S_COLLECT: begin
        if (accept) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_OUTPUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OUTPUT: begin
        if (output_ready) state_d = S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      input_ready_q  <= 1'b0;
      output_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      input_ready_q  <= (state_d == S_COLLECT);
      output_valid_q <= (state_d == S_OUTPUT);
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Streaming argmax over M signed T-bit fc outputs; emits the winning index per vector.
// Define FC_ARGMAX_MAXVAL_EN to also expose the winning value on output_max.
module fc_argmax
  import fc_argmax_pkg::*;
#(
  parameter  int M    = 4,
  parameter  int T    = 16,
  localparam int IDXW = idx_width(M)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic signed [T-1:0]    input_data,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic        [IDXW-1:0] output_data
`ifdef FC_ARGMAX_MAXVAL_EN
  ,
  output logic signed [T-1:0]    output_max
`endif
);

  logic            accept, first_beat, last_beat;
  logic [IDXW-1:0] cnt;

  fc_argmax_ctrl #(
    .M    (M),
    .IDXW (IDXW)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .output_ready (output_ready),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .accept       (accept),
    .first_beat   (first_beat),
    .last_beat    (last_beat),
    .cnt          (cnt)
  );

  logic signed [T-1:0] best_q, best_d, win_val;
  logic [IDXW-1:0]     best_idx_q, best_idx_d, win_idx;
  logic [IDXW-1:0]     out_idx_q, out_idx_d;
  logic                take;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    take       = first_beat || (input_data > best_q);
    win_val    = take ? input_data : best_q;
    win_idx    = take ? cnt : best_idx_q;
    best_d     = accept ? win_val : best_q;
    best_idx_d = accept ? win_idx : best_idx_q;
    out_idx_d  = last_beat ? win_idx : out_idx_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q     <= '0;
      best_idx_q <= '0;
      out_idx_q  <= '0;
    end else begin
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign output_data = out_idx_q;

`ifdef FC_ARGMAX_MAXVAL_EN
  logic signed [T-1:0] out_max_q, out_max_d;

  always_comb begin
    out_max_d = last_beat ? win_val : out_max_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_max_q <= '0;
    end else begin
      out_max_q <= out_max_d;
    end
  end

  assign output_max = out_max_q;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax (M=4, T=16) with directed vectors.
module tb_fc_argmax;

  logic               clk;
  logic               reset;
  logic               input_valid;
  logic               input_ready;
  logic signed [15:0] input_data;
  logic               output_valid;
  logic               output_ready;
  logic [1:0]         output_data;
`ifdef FC_ARGMAX_MAXVAL_EN
  logic signed [15:0] output_max;
`endif

  fc_argmax #(
    .M (4),
    .T (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
`ifdef FC_ARGMAX_MAXVAL_EN
    ,
    .output_max   (output_max)
`endif
  );

  typedef struct {
    int idx;
    int mx;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: a result is consumed whenever valid and ready are both high.
  always @(negedge clk) begin
    if (reset && output_valid && output_ready) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_result: got idx %0d, expected no result", output_data);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("result_idx", int'(output_data), e.idx);
`ifdef FC_ARGMAX_MAXVAL_EN
        checkOutput("result_max", int'(output_max), e.mx);
`endif
      end
    end
  end

  task automatic driveBeat(input logic signed [15:0] val);
    bit got;
    input_valid = 1'b1;
    input_data  = val;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (input_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL input_ready_timeout: got ready=0, expected ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    input_data  = 16'sh7fff;
  endtask

  task automatic applyStimulus(input logic signed [15:0] v0, input logic signed [15:0] v1,
                               input logic signed [15:0] v2, input logic signed [15:0] v3,
                               input bit gap, input int exp_idx, input int exp_max);
    logic signed [15:0] v [4];
    exp_t e;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    e.idx = exp_idx;
    e.mx  = exp_max;
    expQ.push_back(e);
    for (int i = 0; i < 4; i++) begin
      driveBeat(v[i]);
      if (gap && i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("latency_valid", int'(output_valid), 1);
    checkOutput("latency_ready_low", int'(input_ready), 0);
  endtask

  initial begin
    reset        = 1'b0;
    input_valid  = 1'b1;
    input_data   = 16'sd123;
    output_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_input_ready", int'(input_ready), 0);
    checkOutput("rst_output_valid", int'(output_valid), 0);
    checkOutput("rst_output_data", int'(output_data), 0);
`ifdef FC_ARGMAX_MAXVAL_EN
    checkOutput("rst_output_max", int'(output_max), 0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", int'(input_ready), 1);
    input_valid = 1'b0;

    applyStimulus(-16'sd103, 16'sd27, 16'sd116, -16'sd8, 1'b0, 2, 116);
    applyStimulus(-16'sd5, -16'sd5, -16'sd9, -16'sd5, 1'b0, 0, -5);
    applyStimulus(-16'sd32768, 16'sd32767, 16'sd32767, 16'sd0, 1'b0, 1, 32767);

    // Backpressure: hold the result for five cycles.
    @(posedge clk);
    #1;
    output_ready = 1'b0;
    applyStimulus(-16'sd1, 16'sd5, 16'sd40, 16'sd3, 1'b0, 2, 40);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_valid", int'(output_valid), 1);
      checkOutput("bp_idx", int'(output_data), 2);
      checkOutput("bp_input_ready", int'(input_ready), 0);
    end
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    applyStimulus(16'sd1, 16'sd2, 16'sd3, 16'sd4, 1'b0, 3, 4);

    applyStimulus(16'sd0, 16'sd7, 16'sd7, 16'sd100, 1'b1, 3, 100);

    // Abort a partial vector with an asynchronous reset.
    @(posedge clk);
    #1;
    driveBeat(16'sd50);
    driveBeat(16'sd60);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_output_valid", int'(output_valid), 0);
    checkOutput("abort_input_ready", int'(input_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(16'sd9, 16'sd1, 16'sd2, 16'sd3, 1'b0, 0, 9);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
